// File: rtl/rv32i_load_store_unit_if.sv
// ---------------------------------------------------------------------------
// rv32i_load_store_unit_if
// Shared (von Neumann) memory bus between the load/store unit and memory.
//   mem_req    LSU -> mem  bus request, held for the whole access
//   mem_we     LSU -> mem  1 = write
//   mem_addr   LSU -> mem  word-aligned byte address
//   mem_wstrb  LSU -> mem  byte-lane write enables (0000 for reads)
//   mem_wdata  LSU -> mem  lane-replicated write data
//   mem_rdata  mem -> LSU  read data, valid while mem_ready is high
//   mem_ready  mem -> LSU  access completes in this cycle
// Modports: master (LSU side), slave (memory side).
// ---------------------------------------------------------------------------
interface rv32i_load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/rv32i_load_store_unit.sv
// ---------------------------------------------------------------------------
// rv32i_load_store_unit
// Multi-cycle RV32I load/store stage. Performs one byte/halfword/word access
// over the shared memory bus using a req/ready handshake and returns sign- or
// zero-extended load data with a one-cycle completion pulse.
//
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles without mem_ready before a timeout error
//                   (0 disables the timeout)
// Ports:
//   clk         clock, rising edge
//   resetn      synchronous active-low reset
//   lsu_start   begin an access (sampled only while idle)
//   lsu_store   1 = store, 0 = load
//   funct3      RV32I width code
//   addr        effective address
//   store_data  rs2 value
//   mem         memory bus (master modport)
//   lsu_busy    unit is not idle
//   lsu_done    one-cycle completion pulse
//   load_data   extended load result, held until the next completion
//   lsu_err     error flag, valid with lsu_done
//   err_cause   00 none, 01 illegal funct3, 10 misaligned, 11 timeout
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses (cause 10, no bus request). Undefined, halfwords ignore
// addr[0] and words ignore addr[1:0].
// ---------------------------------------------------------------------------
module rv32i_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           lsu_start,
    input  logic                           lsu_store,
    input  logic [2:0]                     funct3,
    input  logic [31:0]                    addr,
    input  logic [31:0]                    store_data,
    rv32i_load_store_unit_if.master        mem,
    output logic                           lsu_busy,
    output logic                           lsu_done,
    output logic [31:0]                    load_data,
    output logic                           lsu_err,
    output logic [1:0]                     err_cause
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t        state_reg, state_next;

    logic [31:0]   addr_reg;
    logic [3:0]    wstrb_reg;
    logic [31:0]   wdata_reg;
    logic          we_reg;
    logic [2:0]    funct3_reg;
    logic [1:0]    lane_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   load_data_reg;
    logic [1:0]    cause_reg;

    // ------------------------------------------------------------------
    // Request decode from the live inputs (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic [1:0]  req_width;
    logic        req_illegal;
    logic        req_misalign;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;

    assign req_width = funct3[1:0];

    // Loads allow 000/001/010/100/101, stores only 000/001/010.
    assign req_illegal = lsu_store ? (funct3[2] || (req_width == 2'b11))
                                   : ((req_width == 2'b11) || (funct3 == 3'b110));

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misalign = ((req_width == 2'b01) && addr[0]) ||
                          ((req_width == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    // Per-lane strobe and write data. Halfword lanes follow addr[1] only, so
    // an odd halfword address falls back to the aligned halfword when the
    // trap is disabled.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            localparam int         HOFS = 8 * (gi % 2);

            assign req_wstrb[gi] = !lsu_store             ? 1'b0 :
                                   (req_width == 2'b00)   ? (addr[1:0] == LANE) :
                                   (req_width == 2'b01)   ? (addr[1] == LANE[1]) :
                                                            1'b1;

            assign req_wdata[8*gi +: 8] = (req_width == 2'b00) ? store_data[7:0] :
                                          (req_width == 2'b01) ? store_data[HOFS +: 8] :
                                                                 store_data[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load lane extraction from the latched width code and address bits
    // ------------------------------------------------------------------
    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [31:0] load_ext;

    assign byte_shift = mem.mem_rdata >> {lane_reg, 3'b000};
    assign half_shift = mem.mem_rdata >> {lane_reg[1], 4'b0000};

    always_comb begin
        load_ext = mem.mem_rdata;
        case (funct3_reg)
            3'b000:  load_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_ext = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b100:  load_ext = {24'd0, byte_shift[7:0]};
            3'b101:  load_ext = {16'd0, half_shift[15:0]};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    // A ready in the limit cycle still completes normally because the REQ
    // branch checks mem_ready before the timeout.
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_reg == TIMEOUT_LIMIT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (lsu_start) begin
                    if (req_illegal || req_misalign) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_ready) begin
                    state_next = ST_RESP;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_reg      <= '0;
            wstrb_reg     <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
            funct3_reg    <= '0;
            lane_reg      <= '0;
            count_reg     <= '0;
            load_data_reg <= '0;
            cause_reg     <= CAUSE_NONE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (lsu_start) begin
                        if (req_illegal) begin
                            cause_reg     <= CAUSE_ILLEGAL;
                            load_data_reg <= '0;
                        end else if (req_misalign) begin
                            cause_reg     <= CAUSE_MISALIGN;
                            load_data_reg <= '0;
                        end else begin
                            cause_reg  <= CAUSE_NONE;
                            addr_reg   <= {addr[31:2], 2'b00};
                            wstrb_reg  <= req_wstrb;
                            wdata_reg  <= req_wdata;
                            we_reg     <= lsu_store;
                            funct3_reg <= funct3;
                            lane_reg   <= addr[1:0];
                            count_reg  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ready) begin
                        if (!we_reg) begin
                            load_data_reg <= load_ext;
                        end
                    end else if (timeout_hit) begin
                        cause_reg     <= CAUSE_TIMEOUT;
                        load_data_reg <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem.mem_req   = (state_reg == ST_REQ);
    assign mem.mem_we    = we_reg && (state_reg == ST_REQ);
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wstrb = wstrb_reg;
    assign mem.mem_wdata = wdata_reg;

    assign lsu_busy  = (state_reg != ST_IDLE);
    assign lsu_done  = (state_reg == ST_RESP) || (state_reg == ST_ERR);
    assign lsu_err   = (state_reg == ST_ERR);
    assign err_cause = (state_reg == ST_ERR) ? cause_reg : CAUSE_NONE;
    assign load_data = load_data_reg;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32i_load_store_unit
// Directed and randomized accesses against the load/store unit. A small
// arithmetic reference model derives the expected bus signals, error causes
// and load results from the access description.
// ---------------------------------------------------------------------------
module tb_rv32i_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        resetn;
    logic        lsu_start;
    logic        lsu_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] load_data;
    logic        lsu_err;
    logic [1:0]  err_cause;

    int checks = 0;
    int errors = 0;
    int op_count = 0;
    logic [31:0] exp_load = '0;

    rv32i_load_store_unit_if bus ();

    rv32i_load_store_unit #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .lsu_start  (lsu_start),
        .lsu_store  (lsu_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem        (bus.master),
        .lsu_busy   (lsu_busy),
        .lsu_done   (lsu_done),
        .load_data  (load_data),
        .lsu_err    (lsu_err),
        .err_cause  (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit m_legal(bit st, bit [2:0] f3);
        if (st) return (f3 <= 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic int m_size(bit [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic bit m_misalign(bit [2:0] f3, bit [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % m_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Byte offset of the accessed item inside the word, after alignment.
    function automatic int m_off(bit [2:0] f3, bit [31:0] a);
        int o;
        o = a % 4;
        return o - (o % m_size(f3));
    endfunction

    function automatic logic [3:0] m_wstrb(bit st, bit [2:0] f3, bit [31:0] a);
        if (!st) return 4'd0;
        return 4'(((1 << m_size(f3)) - 1) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wdata(bit [2:0] f3, bit [31:0] sd);
        case (m_size(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(bit [2:0] f3, bit [31:0] a, bit [31:0] rd);
        longint v;
        int     bits;
        bits = 8 * m_size(f3);
        v = longint'(rd >> (8 * m_off(f3, a))) & ((64'd1 << bits) - 1);
        if (f3 < 3'd4 && bits < 32 && v >= (64'd1 << (bits - 1)))
            v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: start in the current cycle, memory answers after dly
    // REQ cycles (dly > TO means never).
    task automatic run_op(input bit st, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] sd, input bit [31:0] rd, input int dly);
        bit    e_err;
        bit    timed_out;
        bit    done_seen;
        logic [1:0] e_cause;
        e_err   = !m_legal(st, f3) || m_misalign(f3, a);
        e_cause = !m_legal(st, f3) ? 2'b01 : 2'b10;
        timed_out = 1'b0;
        done_seen = 1'b0;

        lsu_start      = 1'b1;
        lsu_store      = st;
        funct3         = f3;
        addr           = a;
        store_data     = sd;
        bus.mem_ready  = 1'b0;
        step();
        // Inputs may change and start is ignored once the access is running.
        lsu_start  = 1'($urandom % 2);
        lsu_store  = 1'($urandom % 2);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;

        if (e_err) begin
            chk("err_done", 32'(lsu_done), 32'd1);
            chk("err_flag", 32'(lsu_err), 32'd1);
            chk("err_cause", 32'(err_cause), 32'(e_cause));
            chk("err_no_req", 32'(bus.mem_req), 32'd0);
            exp_load = '0;
            chk("err_load_zero", load_data, exp_load);
        end else begin
            for (int c = 0; c <= TO; c++) begin
                chk("req", 32'(bus.mem_req), 32'd1);
                chk("req_busy", 32'(lsu_busy), 32'd1);
                chk("req_no_done", 32'(lsu_done), 32'd0);
                chk("req_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
                chk("req_we", 32'(bus.mem_we), 32'(st));
                chk("req_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb(st, f3, a)));
                if (st) chk("req_wdata", bus.mem_wdata, m_wdata(f3, sd));
                if (c == dly) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rd;
                    step();
                    done_seen = 1'b1;
                    break;
                end
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                if (c == TO) timed_out = 1'b1;
                lsu_start = 1'($urandom % 2);
                step();
            end
            bus.mem_ready = 1'($urandom % 2);
            bus.mem_rdata = $urandom;
            chk("done", 32'(lsu_done), 32'd1);
            chk("done_no_req", 32'(bus.mem_req), 32'd0);
            if (timed_out || !done_seen) begin
                chk("to_err", 32'(lsu_err), 32'd1);
                chk("to_cause", 32'(err_cause), 32'd3);
                exp_load = '0;
            end else begin
                chk("ok_err", 32'(lsu_err), 32'd0);
                chk("ok_cause", 32'(err_cause), 32'd0);
                if (!st) exp_load = m_load(f3, a, rd);
            end
            chk("done_load", load_data, exp_load);
        end

        // Start during the done cycle must be ignored.
        lsu_start = 1'($urandom % 2);
        step();
        lsu_start     = 1'b0;
        bus.mem_ready = 1'b0;
        chk("idle_busy", 32'(lsu_busy), 32'd0);
        chk("idle_done", 32'(lsu_done), 32'd0);
        chk("idle_req", 32'(bus.mem_req), 32'd0);
        chk("idle_load", load_data, exp_load);
        op_count++;
        $display("op %0d store=%0d f3=%0d addr=%h sd=%h rd=%h dly=%0d load_data=%h err=%0d",
                 op_count, st, f3, a, sd, rd, dly, load_data, e_err || timed_out);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        resetn        = 1'b0;
        lsu_start     = 1'b0;
        lsu_store     = 1'b0;
        funct3        = 3'd0;
        addr          = '0;
        store_data    = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        step();
        step();

        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_busy", 32'(lsu_busy), 32'd0);
        chk("rst_done", 32'(lsu_done), 32'd0);
        chk("rst_err", 32'(lsu_err), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_cause", 32'(err_cause), 32'd0);
        resetn = 1'b1;
        step();

        // LW, ready in first REQ cycle
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        chk("lw_value", load_data, 32'hDEAD_BEEF);
        // LB / LBU at byte 3
        run_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 0);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        run_op(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 1);
        chk("lbu_value", load_data, 32'h0000_0080);
        // SB at byte 2; load_data must be unchanged
        run_op(1'b1, 3'b000, 32'h302, 32'h1234_5678, 32'h0, 0);
        chk("sb_keeps_load", load_data, 32'h0000_0080);
        // SH upper, SW
        run_op(1'b1, 3'b001, 32'h402, 32'hCAFE_BABE, 32'h0, 2);
        run_op(1'b1, 3'b010, 32'h500, 32'hA5A5_1234, 32'h0, 1);
        // Stall 3 cycles, ready exactly at the timeout limit, and timeout
        run_op(1'b0, 3'b001, 32'h602, 32'h0, 32'h8001_7FFF, 3);
        run_op(1'b0, 3'b101, 32'h700, 32'h0, 32'h1234_F00D, TO);
        run_op(1'b0, 3'b010, 32'h800, 32'h0, 32'h1111_1111, TO + 3);
        chk("timeout_load_zero", load_data, 32'd0);
        // Illegal funct3
        run_op(1'b0, 3'b011, 32'h900, 32'h0, 32'h0, 0);
        run_op(1'b1, 3'b100, 32'h904, 32'h0, 32'h0, 0);
        // LH at odd address
        run_op(1'b0, 3'b001, 32'h101, 32'h0, 32'hAABB_CCDD, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_odd_trap", load_data, 32'd0);
`else
        chk("lh_odd_lane0", load_data, 32'hFFFF_CCDD);
`endif

        // Reset in the middle of REQ
        lsu_start = 1'b1;
        lsu_store = 1'b0;
        funct3    = 3'b010;
        addr      = 32'hA00;
        step();
        lsu_start = 1'b0;
        chk("mid_req", 32'(bus.mem_req), 32'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        exp_load = '0;
        chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_busy", 32'(lsu_busy), 32'd0);
        chk("mid_rst_done", 32'(lsu_done), 32'd0);
        chk("mid_rst_addr", bus.mem_addr, 32'd0);
        chk("mid_rst_load", load_data, 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        step();
        chk("late_ready_done", 32'(lsu_done), 32'd0);
        bus.mem_ready = 1'b0;
        step();
        chk("late_ready_done2", 32'(lsu_done), 32'd0);
        chk("late_ready_busy", 32'(lsu_busy), 32'd0);

        // Randomized accesses
        for (int i = 0; i < 150; i++) begin
            run_op(1'($urandom % 2), 3'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, TO + 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
